// File: rtl/hdmi_i2c_pkg.sv
// Shared types and constants for the HDMI transmitter I2C configuration master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdmi_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_TX_BYTE = 3'd2,
        ST_RX_ACK  = 3'd3,
        ST_RESTART = 3'd4,
        ST_RX_BYTE = 3'd5,
        ST_TX_NACK = 3'd6,
        ST_STOP    = 3'd7
    } state_t;

    // Avalon register offsets
    localparam logic [2:0] OFS_CTRL  = 3'd0;
    localparam logic [2:0] OFS_DEV   = 3'd1;
    localparam logic [2:0] OFS_REG   = 3'd2;
    localparam logic [2:0] OFS_WDATA = 3'd3;
    localparam logic [2:0] OFS_RDATA = 3'd4;

    // CTRL write bits
    localparam int CTRL_GO     = 0;
    localparam int CTRL_RW     = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS read bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_ACK_ERR = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_IRQ_EN  = 3;

    // Bit slots in a complete transaction
    localparam int WR_SLOTS = 29;
    localparam int RD_SLOTS = 39;

endpackage

// File: rtl/hdmi_i2c_tick_gen.sv
// Quarter-SCL-period timebase: qtick pulses on the last clk of each quarter, phase = quarter index q0..q3.
// Latency: qtick is combinational from the counter; clear takes effect on the next clock.
// Backpressure: none; counter holds while run=0, clear wins over run.
// Ports: clk, reset_n (async active-low), run, clear -> qtick, phase[1:0].
module hdmi_i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       clear,
    output logic       qtick,
    output logic [1:0] phase
);

    logic [15:0] cnt;

    assign qtick = run && (cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= 16'd0;
            phase <= 2'd0;
        end else if (clear) begin
            cnt   <= 16'd0;
            phase <= 2'd0;
        end else if (run) begin
            if (qtick) begin
                cnt   <= 16'd0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_i2c_master.sv
// I2C master for single-register write/read of the HDMI transmitter, Avalon-MM slave register file.
// Latency: readdata 1 clk after address; busy 1 clk after go; pad enables lag the FSM by 1 clk.
// Backpressure: none on Avalon; go/config writes while busy are dropped, SCL is open-loop (no stretching).
// Ports: clk, reset_n, address[2:0], chipselect, write_n, writedata[31:0] -> readdata[31:0], irq;
//        scl_oe/sda_oe (1 = pull pad low), sda_in (synchronised pad level).
module hdmi_i2c_master
    import hdmi_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in
);

    state_t      state;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        rw;
    logic        irq_en;
    logic [6:0]  dev;
    logic [7:0]  reg_addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;    // 0 = device address, 1 = register address, 2 = third byte

    logic        qtick;
    logic [1:0]  phase;

    logic        wr_en;
    logic        go_acc;
    logic        slot_end;
    logic        sample;
    logic        unused_wdata;

    assign wr_en    = chipselect && !write_n;
    assign go_acc   = wr_en && (address == OFS_CTRL) && writedata[CTRL_GO] && !busy;
    assign slot_end = qtick && (phase == 2'd3);
    assign sample   = qtick && (phase == 2'd2);   // end of q2, SCL has been high for a quarter
    assign irq      = done && irq_en;
    assign unused_wdata = ^writedata[31:8];

    hdmi_i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (busy),
        .clear   (go_acc),
        .qtick   (qtick),
        .phase   (phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rw       <= 1'b0;
            irq_en   <= 1'b0;
            dev      <= 7'd0;
            reg_addr <= 8'd0;
            wdata    <= 8'd0;
            rdata    <= 8'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            // Configuration registers are frozen for the whole transaction
            if (wr_en && !busy) begin
                case (address)
                    OFS_DEV:   dev      <= writedata[6:0];
                    OFS_REG:   reg_addr <= writedata[7:0];
                    OFS_WDATA: wdata    <= writedata[7:0];
                    default: ;
                endcase
            end

            // A go while busy is dropped entirely, irq_en included
            if (wr_en && (address == OFS_CTRL)) begin
                if (!writedata[CTRL_GO]) begin
                    irq_en <= writedata[CTRL_IRQ_EN];
                end else if (!busy) begin
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    ack_err <= 1'b0;
                    rw      <= writedata[CTRL_RW];
                    irq_en  <= writedata[CTRL_IRQ_EN];
                    state   <= ST_START;
                end
            end

            if (busy && sample) begin
                if (state == ST_RX_ACK && sda_in) begin
                    ack_err <= 1'b1;
                end
                if (state == ST_RX_BYTE) begin
                    rx_sh <= {rx_sh[6:0], sda_in};
                end
            end

            if (busy && slot_end) begin
                case (state)
                    ST_START: begin
                        tx_sh    <= {dev, 1'b0};
                        bit_cnt  <= 3'd0;
                        byte_idx <= 2'd0;
                        state    <= ST_TX_BYTE;
                    end
                    ST_TX_BYTE: begin
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: begin
                        bit_cnt <= 3'd0;
                        if (ack_err) begin
                            state <= ST_STOP;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    tx_sh    <= reg_addr;
                                    byte_idx <= 2'd1;
                                    state    <= ST_TX_BYTE;
                                end
                                2'd1: begin
                                    if (rw) begin
                                        state <= ST_RESTART;
                                    end else begin
                                        tx_sh    <= wdata;
                                        byte_idx <= 2'd2;
                                        state    <= ST_TX_BYTE;
                                    end
                                end
                                default: state <= rw ? ST_RX_BYTE : ST_STOP;
                            endcase
                        end
                    end
                    ST_RESTART: begin
                        tx_sh    <= {dev, 1'b1};
                        byte_idx <= 2'd2;
                        state    <= ST_TX_BYTE;
                    end
                    ST_RX_BYTE: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_TX_NACK;
                        end
                    end
                    ST_TX_NACK: state <= ST_STOP;
                    ST_STOP: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (rw && !ack_err) begin
                            rdata <= rx_sh;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // Pad drive for the current slot/quarter; phase[1]=0 means q0-q1
            case (state)
                ST_IDLE: begin
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                end
                ST_START, ST_RESTART: begin
                    scl_oe <= 1'b0;
                    sda_oe <= phase[1];
                end
                ST_TX_BYTE: begin
                    scl_oe <= ~phase[1];
                    sda_oe <= ~tx_sh[7];
                end
                ST_STOP: begin
                    scl_oe <= ~phase[1];
                    sda_oe <= ~phase[1];
                end
                default: begin
                    scl_oe <= ~phase[1];
                    sda_oe <= 1'b0;
                end
            endcase
        end
    end

    // Free-running read mux: reflects the register addressed on the previous cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                OFS_CTRL:  readdata <= {28'd0, irq_en, done, ack_err, busy};
                OFS_DEV:   readdata <= {25'd0, dev};
                OFS_REG:   readdata <= {24'd0, reg_addr};
                OFS_WDATA: readdata <= {24'd0, wdata};
                OFS_RDATA: readdata <= {24'd0, rdata};
                default:   readdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_master.sv
module tb_hdmi_i2c_master;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_in;
    logic        slave_pull;

    int n_checks = 0;
    int n_fail   = 0;

    hdmi_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in)
    );

    // Open-drain wired-AND of master and slave
    assign sda_in = ~sda_oe & ~slave_pull;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bus monitor + slave model ----------------
    logic       mon_clr = 1'b1;
    logic       slave_present = 1'b1;
    logic [7:0] slave_rdata = 8'h00;
    logic [8:0] got[$];          // {byte, 9th bit}
    int         start_cnt;
    logic       prev_scl, prev_sda, first, reading;
    logic [8:0] sh;
    int         bitn, pull_tmr;

    initial slave_pull = 1'b0;

    always @(negedge clk) begin
        logic scl_l, sda_l;
        scl_l = ~scl_oe;
        sda_l = sda_in;
        if (mon_clr) begin
            got.delete();
            start_cnt  = 0;
            bitn       = 0;
            first      = 1'b0;
            reading    = 1'b0;
            sh         = 9'd0;
            pull_tmr   = 0;
            slave_pull = 1'b0;
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
        end else begin
            // ACK is held one slot; released early if SCL never falls (repeated start)
            if (pull_tmr > 0) begin
                pull_tmr = pull_tmr - 1;
                if (pull_tmr == 0) slave_pull = 1'b0;
            end
            if (prev_scl && scl_l && prev_sda && !sda_l) begin
                start_cnt = start_cnt + 1;
                bitn      = 0;
                first     = 1'b1;
                reading   = 1'b0;
            end else if (!prev_scl && scl_l) begin
                sh   = {sh[7:0], sda_l};
                bitn = bitn + 1;
                if (bitn == 9) begin
                    got.push_back(sh);
                    if (first) reading = sh[1] && !sh[0];
                    first = 1'b0;
                    bitn  = 0;
                end
            end else if (prev_scl && !scl_l) begin
                slave_pull = 1'b0;
                pull_tmr   = 0;
                if (slave_present && bitn == 8 && !(reading && !first)) begin
                    slave_pull = 1'b1;
                    pull_tmr   = SLOT;
                end else if (reading && !first && bitn < 8) begin
                    slave_pull = ~slave_rdata[7 - bitn];
                end
            end
            prev_scl = scl_l;
            prev_sda = sda_l;
        end
    end

    // ---------------- helpers ----------------
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic avm_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic avm_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0;
    endtask

    // Expected bus words from the transaction description alone
    task automatic build_exp(input logic rw, input logic [6:0] dv, input logic [7:0] rg,
                             input logic [7:0] wd, input logic present, input logic [7:0] sdata);
        exp_q.delete();
        exp_q.push_back({dv, 1'b0, ~present});
        if (present) begin
            exp_q.push_back({rg, 1'b0});
            if (!rw) begin
                exp_q.push_back({wd, 1'b0});
            end else begin
                exp_q.push_back({dv, 1'b1, 1'b0});
                exp_q.push_back({sdata, 1'b1});
            end
        end
    endtask

    task automatic cmp_bytes(input string tag);
        int n;
        check({tag, "_nbytes"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), {23'd0, got[i]}, {23'd0, exp_q[i]});
    endtask

    // Configure, issue go and count cycles with STATUS.busy set
    task automatic run_xfer(input logic rw, input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] wd,
                            input logic ie, input logic present, input logic [7:0] sdata, output int busy_cyc);
        logic seen;
        slave_present = present;
        slave_rdata   = sdata;
        clear_monitor();
        avm_write(3'd1, {25'd0, dv});
        avm_write(3'd2, {24'd0, rg});
        avm_write(3'd3, {24'd0, wd});
        avm_write(3'd0, {29'd0, ie, rw, 1'b1});
        address  = 3'd0;
        busy_cyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (readdata[0]) begin
                busy_cyc++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       irq_en;
        logic       present;
        logic [7:0] sdata;
        int         exp_busy;
        logic [3:0] exp_status;
        logic [7:0] exp_rdata;
        logic       exp_irq;
        int         exp_starts;
        int         exp_n;
        logic [8:0] exp_b [4];
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [31:0] rd;
        int          bc;
        logic [1:0]  pre;
        logic [7:0]  rdata_model;

        vecs[0] = '{"wr",   1'b0, 7'h39, 8'h41, 8'h10, 1'b1, 1'b1, 8'h00, 29*SLOT, 4'hC, 8'h00, 1'b1, 1, 3,
                    '{9'h0E4, 9'h082, 9'h020, 9'h000}};
        vecs[1] = '{"rd",   1'b1, 7'h39, 8'h00, 8'h00, 1'b0, 1'b1, 8'hAB, 39*SLOT, 4'h4, 8'hAB, 1'b0, 2, 4,
                    '{9'h0E4, 9'h000, 9'h0E6, 9'h157}};
        vecs[2] = '{"nack", 1'b1, 7'h39, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 11*SLOT, 4'hE, 8'hAB, 1'b1, 1, 1,
                    '{9'h0E5, 9'h000, 9'h000, 9'h000}};

        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        reset_n = 1'b1;
        clear_monitor();
        avm_read(3'd0, rd); check("rst_status", rd, 32'd0);
        avm_write(3'd1, 32'hFFFF_FFB9);
        avm_read(3'd1, rd); check("dev_readback", rd, 32'h39);
        for (int a = 5; a < 8; a++) begin
            avm_read(3'(a), rd); check($sformatf("ofs%0d_zero", a), rd, 32'd0);
        end

        // Table-driven transactions
        for (int v = 0; v < 3; v++) begin
            run_xfer(vecs[v].rw, vecs[v].dev, vecs[v].rg, vecs[v].wd, vecs[v].irq_en,
                     vecs[v].present, vecs[v].sdata, bc);
            check({vecs[v].name, "_busy_clk"}, bc, vecs[v].exp_busy);
            avm_read(3'd0, rd); check({vecs[v].name, "_status"}, rd, {28'd0, vecs[v].exp_status});
            avm_read(3'd4, rd); check({vecs[v].name, "_rdata"}, rd, {24'd0, vecs[v].exp_rdata});
            check({vecs[v].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[v].exp_irq});
            check({vecs[v].name, "_starts"}, start_cnt, vecs[v].exp_starts);
            exp_q.delete();
            for (int i = 0; i < vecs[v].exp_n; i++) exp_q.push_back(vecs[v].exp_b[i]);
            cmp_bytes(vecs[v].name);
        end

        // go=0 only touches irq_en
        avm_write(3'd0, 32'h0000_0000);
        avm_read(3'd0, rd); check("irq_en_clear_status", rd, 32'h6);
        check("irq_en_clear_irq", {31'd0, irq}, 32'd0);

        // Busy protection: config write and a second go during a transaction are dropped
        slave_present = 1'b1;
        clear_monitor();
        avm_write(3'd1, 32'h39);
        avm_write(3'd2, 32'h41);
        avm_write(3'd3, 32'h10);
        avm_write(3'd0, 32'h5);
        repeat (100) @(negedge clk);
        avm_write(3'd1, 32'h11);
        avm_write(3'd0, 32'h3);
        avm_write(3'd3, 32'h55);
        rd = 32'h1;
        for (int i = 0; i < 1000 && rd[0]; i++) avm_read(3'd0, rd);
        check("prot_status", rd, 32'hC);
        avm_read(3'd1, rd); check("prot_dev", rd, 32'h39);
        avm_read(3'd3, rd); check("prot_wdata", rd, 32'h10);
        repeat (600) @(negedge clk);
        check("prot_starts", start_cnt, 1);
        build_exp(1'b0, 7'h39, 8'h41, 8'h10, 1'b1, 8'h00);
        cmp_bytes("prot");

        // Reset in the middle of the register-address byte
        clear_monitor();
        avm_write(3'd0, 32'h5);
        repeat (243) @(negedge clk);
        pre = {scl_oe, sda_oe};
        check("midrst_pre_oe", {30'd0, pre}, 32'h3);
        reset_n = 1'b0;
        #1;
        check("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        avm_read(3'd0, rd); check("midrst_status", rd, 32'd0);
        run_xfer(1'b0, 7'h39, 8'h41, 8'h10, 1'b0, 1'b1, 8'h00, bc);
        check("midrst_next_busy", bc, 29 * SLOT);
        check("midrst_next_starts", start_cnt, 1);
        build_exp(1'b0, 7'h39, 8'h41, 8'h10, 1'b1, 8'h00);
        cmp_bytes("midrst_next");

        // Randomised transactions against the reference model
        rdata_model = 8'h00;
        for (int t = 0; t < 8; t++) begin
            logic       r_rw, r_ie, r_pr;
            logic [6:0] r_dev;
            logic [7:0] r_rg, r_wd, r_sd;
            int         slots;
            r_rw  = 1'($urandom_range(0, 1));
            r_ie  = 1'($urandom_range(0, 1));
            r_pr  = ($urandom_range(0, 3) != 0);
            r_dev = 7'($urandom);
            r_rg  = 8'($urandom);
            r_wd  = 8'($urandom);
            r_sd  = 8'($urandom);
            run_xfer(r_rw, r_dev, r_rg, r_wd, r_ie, r_pr, r_sd, bc);
            slots = !r_pr ? 11 : (r_rw ? 39 : 29);
            if (r_rw && r_pr) rdata_model = r_sd;
            check($sformatf("rnd%0d_busy", t), bc, slots * SLOT);
            avm_read(3'd0, rd);
            check($sformatf("rnd%0d_status", t), rd, {28'd0, r_ie, 1'b1, ~r_pr, 1'b0});
            avm_read(3'd4, rd);
            check($sformatf("rnd%0d_rdata", t), rd, {24'd0, rdata_model});
            check($sformatf("rnd%0d_irq", t), {31'd0, irq}, {31'd0, r_ie});
            check($sformatf("rnd%0d_starts", t), start_cnt, (r_rw && r_pr) ? 2 : 1);
            build_exp(r_rw, r_dev, r_rg, r_wd, r_pr, r_sd);
            cmp_bytes($sformatf("rnd%0d", t));
        end

        // Reset while idle with done and irq_en set
        avm_write(3'd0, 32'h4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("idlerst_irq", {31'd0, irq}, 32'd0);
        check("idlerst_readdata", readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        avm_read(3'd0, rd); check("idlerst_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
